lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store initiator that drives the word-addressed data memory port `mem` (clk, rst, dmem, data_w, addr, data_r) on behalf of the core pipeline.
- Accepts byte/half/word loads and stores on a valid/ready request interface.
- Performs read-modify-write for sub-word stores.
- Sign/zero-extends load data and returns a single-cycle response pulse.
- Rejects misaligned and out-of-range accesses without touching memory.

Parameters:
ADDR_W, 3, word-address width of the attached mem (mem depth = 2**ADDR_W words).

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready at rising edge
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  in  1  load zero-extend (LBU/LHU); ignored for stores and words
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  one-cycle response pulse; no backpressure
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned, illegal size or out-of-range; valid with rsp_valid
dmem  out  1  to mem: 1 = write at next edge, 0 = read
addr  out  ADDR_W  to mem: word index = req_addr[ADDR_W+1:2]
data_w  out  32  to mem: write word
data_r  in  32  from mem: registered read, valid the cycle after addr is presented

Behaviour:
- Reset (async): state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; dmem=0; addr=0; data_w=0.
- All outputs are registered except req_ready, which equals (state == IDLE).
- FSM states: IDLE, LD_WAIT, RMW_WAIT, RMW_WR, ST_WR.
- Error check at acceptance:
  - req_size == 3.
  - Half access with req_addr[0] = 1.
  - Word access with req_addr[1:0] != 0.
  - req_addr[31:ADDR_W+2] != 0.
  - On error: state stays IDLE; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; dmem never asserted. Latency 1.
- Load: IDLE -> LD_WAIT.
  - addr set and dmem=0 from the accept edge E0.
  - At E1, data_r is valid; at E2 it is extracted and extended into rsp_rdata, with rsp_valid=1 for cycle E2-E3. Latency 3.
- Word store: IDLE -> ST_WR.
  - dmem=1 and data_w=req_wdata for cycle E0-E1; mem writes at E1.
  - At E1 dmem returns to 0; rsp_valid for cycle E1-E2. Latency 2.
- Sub-word store: IDLE -> RMW_WAIT -> RMW_WR.
  - Read phase as for a load.
  - At E2, data_w = data_r with the target lane(s) replaced; dmem=1 for cycle E2-E3.
  - rsp_valid for cycle E3-E4. Latency 4.
- Lanes are little-endian:
  - Byte lane = req_addr[1:0]; half lane = req_addr[1].
  - Signed loads replicate the lane MSB into the upper bits.
- Address, size, unsigned flag and wdata are captured at acceptance; request inputs are ignored afterwards.
- The response cycle coincides with the return to IDLE, so a new request may be accepted in the same cycle rsp_valid=1 (back-to-back, no bubble).
- dmem is high for exactly one cycle per store and never during loads or errors.
- Reset mid-operation: outputs clear immediately, the pending access is abandoned, no write occurs and no response is produced.

Decomposition:
- lsu_pkg holds:
  - size enum: SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2.
  - FSM state enum.
  - function is_misaligned(size, addr[1:0]).
- Sub-module lsu_align: purely combinational.
  - Load path: extract + extend (data_r, lane, size, unsigned) -> 32-bit.
  - Store path: merge (old word, wdata, lane, size) -> 32-bit.
- lsu_mem_ctrl holds the FSM, capture registers and error check.

Test Plan:
- SW 0xaaaaaaaa @0x0, then SW 0xbbbbbbbb @0x4 issued in the response cycle -> dmem=1 with addr=0 then addr=1; two rsp pulses, each 2 cycles after its accept; rsp_err=0.
- mem[2]=0x123480ff; LW @0x8 -> 0x123480ff at latency 3; LB @0x9 -> 0xffffff80; LBU @0x9 -> 0x00000080; LH @0xA -> 0x00001234; LH @0x8 -> 0xffff80ff.
- mem[2]=0xcccccccc; SB 0x55 @0xB -> read addr=2, then dmem=1 with data_w=0x55cccccc, rsp at 4 cycles; SH 0x1234 @0x8 -> 0x55cc1234.
- LW @0x6, LH @0x3, req_size=3 and SW @0x20 with ADDR_W=3 -> each gives rsp_err=1 one cycle after accept, rsp_rdata=0, dmem stays 0 throughout.
- Assert rst during RMW_WAIT of SB @0x9 -> dmem, addr, data_w and rsp_valid read 0 before the next edge; mem[2] unchanged; after release, LW @0x8 returns the original word.
- Hold req_valid during LD_WAIT -> req_ready=0, no second accept until IDLE; the request is accepted exactly once.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory controller.
package lsu_pkg;

    // Access size encoding on req_size; 2'd3 is the illegal encoding.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Controller FSM states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_WAIT  = 3'd1,
        RMW_WAIT = 3'd2,
        RMW_WR   = 3'd3,
        ST_WR    = 3'd4
    } state_e;

    // Halves must sit on even bytes, words on multiples of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if (size == SZ_H) begin
            mis = lo[0];
        end else if (size == SZ_W) begin
            mis = (lo != 2'd0);
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: load extract/extend and sub-word store merge (combinational).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] mask_sh;
    logic [31:0] data_sh;

    // Load path: shift the addressed lane down, then sign- or zero-extend it.
    always_comb begin
        shifted = rdata_i >> {lane_i, 3'b000};
        load_o  = rdata_i;
        if (size_i == SZ_B) begin
            load_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
        end else if (size_i == SZ_H) begin
            load_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
        end
    end

    // Store path: replace only the target lane(s) of the old word with new data.
    always_comb begin
        mask = 32'hffff_ffff;
        if (size_i == SZ_B) begin
            mask = 32'h0000_00ff;
        end else if (size_i == SZ_H) begin
            mask = 32'h0000_ffff;
        end
        mask_sh = mask << {lane_i, 3'b000};
        data_sh = wdata_i << {lane_i, 3'b000};
        merge_o = (rdata_i & ~mask_sh) | (data_sh & mask_sh);
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-addressed, registered-read data memory.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              dmem,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data_w,
    input  logic [31:0]       data_r
);

    state_e              state_q, state_d;
    logic                phase_q, phase_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                dmem_q, dmem_d;
    logic [31:0]         data_w_q, data_w_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [1:0]          lane_q, lane_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                req_err;
    logic [31:0]         load_data;
    logic [31:0]         merge_data;

    lsu_align u_align (
        .rdata_i    (data_r),
        .lane_i     (lane_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (load_data),
        .merge_o    (merge_data)
    );

    // Reject illegal size, misalignment, or any address bit above the memory span.
    always_comb begin
        req_err = (req_size == 2'd3) ||
                  is_misaligned(req_size, req_addr[1:0]) ||
                  ((req_addr >> (ADDR_W + 2)) != 32'd0);
    end

    // Next-state and registered-output logic; the read phase takes two cycles
    // because data_r lags addr by one cycle and is sampled the cycle after.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        dmem_d      = 1'b0;
        data_w_d    = data_w_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        lane_d      = lane_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        lane_d  = req_addr[1:0];
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        wdata_d = req_wdata;
                        addr_d  = req_addr[ADDR_W+1:2];
                        phase_d = 1'b0;
                        if (!req_we) begin
                            state_d = LD_WAIT;
                        end else if (req_size == SZ_W) begin
                            state_d  = ST_WR;
                            dmem_d   = 1'b1;
                            data_w_d = req_wdata;
                        end else begin
                            state_d = RMW_WAIT;
                        end
                    end
                end
            end
            LD_WAIT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data;
                end
            end
            RMW_WAIT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    state_d  = RMW_WR;
                    dmem_d   = 1'b1;
                    data_w_d = merge_data;
                end
            end
            RMW_WR, ST_WR: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any pending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            addr_q      <= '0;
            dmem_q      <= 1'b0;
            data_w_q    <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            lane_q      <= 2'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            dmem_q      <= dmem_d;
            data_w_q    <= data_w_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dmem      = dmem_q;
    assign addr      = addr_q;
    assign data_w    = data_w_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural registered-read memory.
module tb_lsu_mem_ctrl;

    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          dmem;
    logic [AW-1:0] addr;
    logic [31:0]   data_w;
    logic [31:0]   data_r;

    logic [31:0]   mem [0:(1<<AW)-1];

    int total;
    int bad;

    lsu_mem_ctrl #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .dmem         (dmem),
        .addr         (addr),
        .data_w       (data_w),
        .data_r       (data_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: write when dmem is high, read data registered one cycle later.
    always @(posedge clk) begin
        if (dmem) mem[addr] <= data_w;
        data_r <= mem[addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, then walk lat samples after acceptance checking the
    // response timing, data, error flag and every memory write cycle.
    task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input int lat, input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_wr, input logic [31:0] exp_wdata);
        int wr;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        wr = 0;
        if (!exp_err) chk({tag, " addr"}, 32'(addr), 32'(a[4:2]));
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) step();
            if (dmem) begin
                wr++;
                chk({tag, " wr_addr"}, 32'(addr), 32'(a[4:2]));
                chk({tag, " wr_data"}, data_w, exp_wdata);
            end
            if (k < lat) begin
                chk({tag, " early_rsp"}, 32'(rsp_valid), 32'd0);
            end else begin
                chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, " rdata"}, rsp_rdata, exp_rd);
                chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
            end
        end
        chk({tag, " writes"}, 32'(wr), 32'(exp_wr));
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        step();
        step();

        chk("rst ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rdata", rsp_rdata, 32'd0);
        chk("rst err", 32'(rsp_err), 32'd0);
        chk("rst dmem", 32'(dmem), 32'd0);
        chk("rst addr", 32'(addr), 32'd0);
        chk("rst data_w", data_w, 32'd0);
        rst = 1'b0;
        step();

        // Back-to-back word stores, second offered in the first response cycle.
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'haaaa_aaaa; req_valid = 1'b1;
        step();
        chk("b2b1 dmem", 32'(dmem), 32'd1);
        chk("b2b1 addr", 32'(addr), 32'd0);
        chk("b2b1 data_w", data_w, 32'haaaa_aaaa);
        chk("b2b1 busy", 32'(req_ready), 32'd0);
        req_addr = 32'h4; req_wdata = 32'hbbbb_bbbb;
        step();
        chk("b2b1 rsp", 32'(rsp_valid), 32'd1);
        chk("b2b1 err", 32'(rsp_err), 32'd0);
        chk("b2b1 dmem off", 32'(dmem), 32'd0);
        chk("b2b ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("b2b2 dmem", 32'(dmem), 32'd1);
        chk("b2b2 addr", 32'(addr), 32'd1);
        chk("b2b2 data_w", data_w, 32'hbbbb_bbbb);
        chk("b2b2 no rsp", 32'(rsp_valid), 32'd0);
        step();
        chk("b2b2 rsp", 32'(rsp_valid), 32'd1);
        chk("b2b2 err", 32'(rsp_err), 32'd0);
        chk("mem0", mem[0], 32'haaaa_aaaa);
        chk("mem1", mem[1], 32'hbbbb_bbbb);

        // Loads with extension from mem[2] = 0x123480ff.
        run_req("sw8", 1'b1, 2'd2, 1'b0, 32'h8, 32'h1234_80ff, 2, 32'h0, 1'b0, 1, 32'h1234_80ff);
        run_req("lw8", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 3, 32'h1234_80ff, 1'b0, 0, 32'h0);
        run_req("lb9", 1'b0, 2'd0, 1'b0, 32'h9, 32'h0, 3, 32'hffff_ff80, 1'b0, 0, 32'h0);
        run_req("lbu9", 1'b0, 2'd0, 1'b1, 32'h9, 32'h0, 3, 32'h0000_0080, 1'b0, 0, 32'h0);
        run_req("lhA", 1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 3, 32'h0000_1234, 1'b0, 0, 32'h0);
        run_req("lh8", 1'b0, 2'd1, 1'b0, 32'h8, 32'h0, 3, 32'hffff_80ff, 1'b0, 0, 32'h0);
        run_req("lhu8", 1'b0, 2'd1, 1'b1, 32'h8, 32'h0, 3, 32'h0000_80ff, 1'b0, 0, 32'h0);

        // Sub-word stores via read-modify-write.
        run_req("swC", 1'b1, 2'd2, 1'b0, 32'h8, 32'hcccc_cccc, 2, 32'h0, 1'b0, 1, 32'hcccc_cccc);
        run_req("sbB", 1'b1, 2'd0, 1'b0, 32'hB, 32'hffff_ff55, 4, 32'h0, 1'b0, 1, 32'h55cc_cccc);
        run_req("sh8", 1'b1, 2'd1, 1'b0, 32'h8, 32'hdead_1234, 4, 32'h0, 1'b0, 1, 32'h55cc_1234);
        chk("mem2 rmw", mem[2], 32'h55cc_1234);

        // Rejected accesses.
        run_req("e_lw6", 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
        run_req("e_lh3", 1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
        run_req("e_sz3", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
        run_req("e_sw20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h1111_1111, 1, 32'h0, 1'b1, 0, 32'h0);
        step();
        chk("e idle rsp", 32'(rsp_valid), 32'd0);
        chk("mem0 kept", mem[0], 32'haaaa_aaaa);

        // Reset while a byte store is in its read phase.
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h9; req_wdata = 32'h77; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("mr addr pre", 32'(addr), 32'd2);
        rst = 1'b1;
        #1;
        chk("mr dmem", 32'(dmem), 32'd0);
        chk("mr addr", 32'(addr), 32'd0);
        chk("mr data_w", data_w, 32'd0);
        chk("mr rsp", 32'(rsp_valid), 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("mr post rsp", 32'(rsp_valid), 32'd0);
        chk("mr post dmem", 32'(dmem), 32'd0);
        chk("mr ready", 32'(req_ready), 32'd1);
        chk("mr mem2", mem[2], 32'h55cc_1234);
        run_req("mr lw8", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 3, 32'h55cc_1234, 1'b0, 0, 32'h0);

        // Request held during the load: accepted exactly once.
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h8; req_valid = 1'b1;
        step();
        chk("hold busy1", 32'(req_ready), 32'd0);
        step();
        chk("hold busy2", 32'(req_ready), 32'd0);
        chk("hold no rsp", 32'(rsp_valid), 32'd0);
        step();
        req_valid = 1'b0;
        chk("hold rsp", 32'(rsp_valid), 32'd1);
        chk("hold rdata", rsp_rdata, 32'h55cc_1234);
        chk("hold ready", 32'(req_ready), 32'd1);
        step();
        chk("hold once rsp", 32'(rsp_valid), 32'd0);
        chk("hold once ready", 32'(req_ready), 32'd1);
        step();
        chk("hold once rsp2", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
